// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the IF and ID stages.
// A DEPTH-entry FIFO of {pc, inst, excepttype} lets fetch run ahead while ID
// is stalled. One registered entry per cycle is presented to ID. When the
// FIFO is empty, the incoming IF entry bypasses straight into the output
// register, so an unstalled pipeline sees the same 1-cycle latency as a plain
// IF/ID register.
module inst_fetch_queue #(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 32,
   parameter int INST_W    = 32,
   parameter int EXC_W     = 32,
   parameter int FAULT_BIT = 13
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      if_valid,
   input  logic [ADDR_W-1:0]         if_pc,
   input  logic [INST_W-1:0]         if_inst,
   input  logic [EXC_W-1:0]          if_excepttype,
   output logic                      if_stallreq,
   input  logic                      id_stall,
   output logic                      id_valid,
   output logic [ADDR_W-1:0]         id_pc,
   output logic [INST_W-1:0]         id_inst,
   output logic [EXC_W-1:0]          id_excepttype,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // Pointers carry one extra MSB so that full and empty can be told apart.
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;

   logic [ADDR_W-1:0] mem_pc   [DEPTH];
   logic [INST_W-1:0] mem_inst [DEPTH];
   logic [EXC_W-1:0]  mem_exc  [DEPTH];

   logic              empty;
   logic              full;
   logic              pop_slot;
   logic              pop;
   logic              bypass;
   logic              accept;
   logic [INST_W-1:0] masked_inst;

   assign empty    = (head == tail);
   assign full     = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);

   // The output register loads whenever ID is not holding its entry.
   assign pop_slot = !id_stall;
   assign pop      = pop_slot && !empty;
   assign bypass   = pop_slot && empty && if_valid;

   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign accept   = if_valid && !bypass && (!full || pop_slot);

   assign if_stallreq = full && id_stall;
   assign count       = tail - head;

   // A fetch fault carries no usable instruction, so it is stored as zero.
   assign masked_inst = if_excepttype[FAULT_BIT] ? '0 : if_inst;

   // Entry storage: written at the tail on every accepted push.
   // NOTE: the storage arrays are not reset; head/tail define which slots are
   // live, so resetting the data would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (!rst && !flush && accept) begin
         mem_pc[tail[AW-1:0]]   <= if_pc;
         mem_inst[tail[AW-1:0]] <= masked_inst;
         mem_exc[tail[AW-1:0]]  <= if_excepttype;
      end
   end

   // Pointer update and the ID-facing output register; rst beats flush beats normal flow.
   always_ff @(posedge clk) begin
      if (rst) begin
         head          <= '0;
         tail          <= '0;
         id_valid      <= 1'b0;
         id_pc         <= '0;
         id_inst       <= '0;
         id_excepttype <= '0;
      end else if (flush) begin
         head          <= tail;
         id_valid      <= 1'b0;
         id_pc         <= '0;
         id_inst       <= '0;
         id_excepttype <= '0;
      end else begin
         if (pop) begin
            head <= head + 1'b1;
         end
         if (accept) begin
            tail <= tail + 1'b1;
         end
         if (pop_slot) begin
            if (!empty) begin
               id_valid      <= 1'b1;
               id_pc         <= mem_pc[head[AW-1:0]];
               id_inst       <= mem_inst[head[AW-1:0]];
               id_excepttype <= mem_exc[head[AW-1:0]];
            end else if (if_valid) begin
               id_valid      <= 1'b1;
               id_pc         <= if_pc;
               id_inst       <= masked_inst;
               id_excepttype <= if_excepttype;
            end else begin
               id_valid      <= 1'b0;
               id_pc         <= '0;
               id_inst       <= '0;
               id_excepttype <= '0;
            end
         end
      end
   end

endmodule
